// File: rtl/srl_ra_loader.sv
// rtl/srl_ra_loader.sv - assembles a chunked stream into words and shifts them into an SRL table
module srl_ra_loader #(
    parameter int WIDTH    = 32,
    parameter int IN_WIDTH = 8,
    parameter int DEEP     = 32,
    localparam int CHUNKS   = WIDTH / IN_WIDTH,
    localparam int CNT_BITS = $clog2(DEEP + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [IN_WIDTH-1:0] s_tdata,
    input  logic                s_tvalid,
    output logic                s_tready,
    input  logic                s_tlast,
    output logic                srl_we_o,
    output logic [WIDTH-1:0]    srl_data_o,
    output logic                busy_o,
    output logic                tbl_valid_o,
    output logic                load_err_o,
    output logic [CNT_BITS-1:0] word_cnt_o
);
    localparam int IDX_BITS = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_BITS-1:0] idx_q, idx_d;
    logic [WIDTH-1:0]    asm_q, asm_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic                we_q, we_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    // s_tlast seen on the very last chunk; resolved into valid/err when FLUSH exits
    logic                ok_q, ok_d;

    logic [WIDTH-1:0]    asm_word;
    logic                last_chunk;
    logic                last_word;

    always_comb begin
        asm_word = asm_q;
        asm_word[int'(idx_q) * IN_WIDTH +: IN_WIDTH] = s_tdata;
        last_chunk = (idx_q == IDX_BITS'(CHUNKS - 1));
        last_word  = (cnt_q == CNT_BITS'(DEEP - 1));

        state_d = state_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        data_d  = data_q;
        we_d    = 1'b0;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        err_d   = err_q;
        ok_d    = ok_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    ok_d    = 1'b0;
                end
            end
            LOAD: begin
                if (s_tvalid) begin
                    asm_d = asm_word;
                    if (last_chunk) begin
                        we_d   = 1'b1;
                        data_d = asm_word;
                        cnt_d  = cnt_q + 1'b1;
                        idx_d  = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                    if (last_chunk && last_word) begin
                        state_d = FLUSH;
                        ok_d    = s_tlast;
                    end else if (s_tlast) begin
                        // early end: any word this chunk completed is still written above
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            FLUSH: begin
                state_d = IDLE;
                valid_d = ok_q;
                err_d   = ~ok_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            asm_q   <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            ok_q    <= ok_d;
        end
    end

    assign s_tready    = (state_q == LOAD);
    assign busy_o      = (state_q != IDLE);
    assign srl_we_o    = we_q;
    assign srl_data_o  = data_q;
    assign tbl_valid_o = valid_q;
    assign load_err_o  = err_q;
    assign word_cnt_o  = cnt_q;
endmodule

// File: tb/tb_srl_ra_loader.sv
// tb/tb_srl_ra_loader.sv - table-driven scoreboard bench for srl_ra_loader
module tb_srl_ra_loader;
    localparam int WIDTH    = 32;
    localparam int IN_WIDTH = 8;
    localparam int DEEP     = 16;
    localparam int CNT_BITS = $clog2(DEEP + 1);
    localparam int BEATS    = DEEP * (WIDTH / IN_WIDTH);
    localparam int LIMIT    = 400;

    logic                clk = 1'b0;
    logic                rst;
    logic                start_i;
    logic [IN_WIDTH-1:0] s_tdata;
    logic                s_tvalid;
    logic                s_tready;
    logic                s_tlast;
    logic                srl_we_o;
    logic [WIDTH-1:0]    srl_data_o;
    logic                busy_o;
    logic                tbl_valid_o;
    logic                load_err_o;
    logic [CNT_BITS-1:0] word_cnt_o;

    srl_ra_loader #(.WIDTH(WIDTH), .IN_WIDTH(IN_WIDTH), .DEEP(DEEP)) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .srl_we_o(srl_we_o), .srl_data_o(srl_data_o), .busy_o(busy_o),
        .tbl_valid_o(tbl_valid_o), .load_err_o(load_err_o), .word_cnt_o(word_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tlast_beat;
        int rst_at;
        int start_at;
        bit stall;
        bit flush_start;
        int exp_pulses;
        bit exp_valid;
        bit exp_err;
        int exp_wcnt;
    } vec_t;

    int               n_cmp = 0;
    int               n_fail = 0;
    int               pulses = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] mon_w;
    vec_t             vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (srl_we_o === 1'b1) begin
            pulses++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse got=%h want=none", srl_data_o);
            end else begin
                mon_w = exp_q.pop_front();
                if (srl_data_o !== mon_w) begin
                    n_fail++;
                    $display("FAIL srl_data got=%h want=%h", srl_data_o, mon_w);
                end
            end
        end
    end

    task automatic run_row(input int row, input vec_t v);
        int  b;
        int  cyc;
        bit  acc;
        bit  done;
        pulses = 0;
        exp_q.delete();
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        check($sformatf("r%0d_start_busy", row), busy_o, 1);
        check($sformatf("r%0d_start_valid", row), tbl_valid_o, 0);
        check($sformatf("r%0d_start_err", row), load_err_o, 0);
        check($sformatf("r%0d_start_cnt", row), word_cnt_o, 0);
        b = 0;
        cyc = 0;
        while (b < BEATS && cyc < LIMIT) begin
            if (b == v.rst_at) begin
                rst = 1'b1;
                s_tvalid = 1'b0;
                s_tlast = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                check("rst_tready", s_tready, 0);
                check("rst_we", srl_we_o, 0);
                check("rst_data", srl_data_o, 0);
                check("rst_busy", busy_o, 0);
                check("rst_valid", tbl_valid_o, 0);
                check("rst_err", load_err_o, 0);
                check("rst_cnt", word_cnt_o, 0);
                break;
            end
            s_tvalid = !(v.stall && cyc[0]);
            s_tdata  = IN_WIDTH'(b);
            s_tlast  = (b == v.tlast_beat);
            start_i  = (b == v.start_at) && s_tvalid;
            acc  = s_tvalid && s_tready;
            done = s_tlast;
            @(posedge clk); #1;
            start_i = 1'b0;
            cyc++;
            if (acc) begin
                if (b % 4 == 3)
                    exp_q.push_back({8'(b), 8'(b - 1), 8'(b - 2), 8'(b - 3)});
                b++;
                if (done) break;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (cyc >= LIMIT) begin
            n_cmp++;
            n_fail++;
            $display("FAIL r%0d_timeout got=%0d want<%0d", row, cyc, LIMIT);
        end
        if (b == BEATS) begin
            check($sformatf("r%0d_flush_busy", row), busy_o, 1);
            check($sformatf("r%0d_flush_tready", row), s_tready, 0);
            check($sformatf("r%0d_flush_valid", row), tbl_valid_o, 0);
            start_i = v.flush_start;
            @(posedge clk); #1;
            start_i = 1'b0;
            check($sformatf("r%0d_latency_valid", row), tbl_valid_o, 32'(v.exp_valid));
            check($sformatf("r%0d_idle_busy", row), busy_o, 0);
        end
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("r%0d_pulses", row), pulses, v.exp_pulses);
        check($sformatf("r%0d_queue_left", row), exp_q.size(), 0);
        check($sformatf("r%0d_valid", row), tbl_valid_o, 32'(v.exp_valid));
        check($sformatf("r%0d_err", row), load_err_o, 32'(v.exp_err));
        check($sformatf("r%0d_busy", row), busy_o, 0);
        check($sformatf("r%0d_wcnt", row), word_cnt_o, v.exp_wcnt);
    endtask

    initial begin
        vecs[0] = '{63, -1, -1, 1'b0, 1'b0, 16, 1'b1, 1'b0, 16};
        vecs[1] = '{63, -1, -1, 1'b1, 1'b0, 16, 1'b1, 1'b0, 16};
        vecs[2] = '{10, -1, -1, 1'b0, 1'b0,  2, 1'b0, 1'b1,  2};
        vecs[3] = '{-1, -1, -1, 1'b0, 1'b0, 16, 1'b0, 1'b1, 16};
        vecs[4] = '{63, -1,  5, 1'b0, 1'b1, 16, 1'b1, 1'b0, 16};
        vecs[5] = '{63, 30, -1, 1'b0, 1'b0,  7, 1'b0, 1'b0,  0};
        vecs[6] = '{63, -1, -1, 1'b0, 1'b0, 16, 1'b1, 1'b0, 16};
        vecs[7] = '{ 3, -1, -1, 1'b0, 1'b0,  1, 1'b0, 1'b1,  1};
        vecs[8] = '{62, -1, -1, 1'b0, 1'b0, 15, 1'b0, 1'b1, 15};

        rst = 1'b1;
        start_i = 1'b0;
        s_tdata = '0;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_tready", s_tready, 0);
        check("reset_we", srl_we_o, 0);
        check("reset_data", srl_data_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_valid", tbl_valid_o, 0);
        check("reset_err", load_err_o, 0);
        check("reset_cnt", word_cnt_o, 0);

        for (int i = 0; i < 9; i++) begin
            run_row(i, vecs[i]);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
